// File: rtl/sprite_reader_wall.sv
// Wall_1 sprite read client: turns the VGA beam position into frame-RAM read addresses
// and re-aligns the returned palette index with a three-edge fixed pipeline.
module sprite_reader_wall #(
    parameter int         SPR_W      = 64,
    parameter int         SPR_H      = 33,
    parameter int         ADDR_W     = 19,
    parameter int         DATA_W     = 5,
    parameter logic [1:0] TRANSP_IDX = 2'd0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [9:0]        pos_x_in,
    input  logic [9:0]        pos_y_in,
    input  logic              flip_h_in,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] read_address,
    input  logic [DATA_W-1:0] data_Out,
    output logic [1:0]        pix_idx,
    output logic              pix_valid
);
    localparam int                COL_W    = $clog2(SPR_W);
    localparam logic [10:0]       W11      = 11'(SPR_W);
    localparam logic [10:0]       H11      = 11'(SPR_H);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(SPR_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);

    logic [9:0]        sx_q;
    logic [9:0]        sy_q;
    logic              flip_q;
    logic [9:0]        draw_y_prev_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] row_base_d;
    logic [ADDR_W-1:0] read_address_q;
    logic [ADDR_W-1:0] read_address_d;
    logic              hit1_q;
    logic              hit2_q;
    logic [1:0]        pix_idx_q;
    logic              pix_valid_q;

    logic [10:0]       x11;
    logic [10:0]       y11;
    logic [10:0]       yp11;
    logic [10:0]       sx11;
    logic [10:0]       sy11;
    logic [10:0]       col_off;
    logic [COL_W-1:0]  col;
    logic              h_hit;
    logic              v_hit;
    logic              v_hit_prev;
    logic              hit;
    logic              unused_bits;

    // Widen to 11 bits so a sprite hanging past column/row 1023 clips instead of wrapping.
    assign x11  = {1'b0, DrawX};
    assign y11  = {1'b0, DrawY};
    assign yp11 = {1'b0, draw_y_prev_q};
    assign sx11 = {1'b0, sx_q};
    assign sy11 = {1'b0, sy_q};

    always_comb begin
        h_hit          = (x11 >= sx11) && (x11 < sx11 + W11);
        v_hit          = (y11 >= sy11) && (y11 < sy11 + H11);
        v_hit_prev     = (yp11 >= sy11) && (yp11 < sy11 + H11);
        hit            = h_hit && v_hit;
        col_off        = x11 - sx11;
        col            = flip_q ? (COL_MAX - col_off[COL_W-1:0]) : col_off[COL_W-1:0];
        read_address_d = hit ? (row_base_q + ADDR_W'(col)) : '0;
    end

    // Row base advances by one sprite width per completed sprite line, avoiding a multiplier.
    always_comb begin
        row_base_d = row_base_q;
        if (frame_start) begin
            row_base_d = '0;
        end else if (DrawY != draw_y_prev_q) begin
            if (DrawY == sy_q) begin
                row_base_d = '0;
            end else if (v_hit_prev) begin
                row_base_d = row_base_q + ROW_STEP;
            end
        end
    end

    assign unused_bits = ^{data_Out[DATA_W-1:2], col_off[10:COL_W]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx_q           <= '0;
            sy_q           <= '0;
            flip_q         <= 1'b0;
            draw_y_prev_q  <= '0;
            row_base_q     <= '0;
            read_address_q <= '0;
            hit1_q         <= 1'b0;
            hit2_q         <= 1'b0;
            pix_idx_q      <= '0;
            pix_valid_q    <= 1'b0;
        end else begin
            if (frame_start) begin
                sx_q   <= pos_x_in;
                sy_q   <= pos_y_in;
                flip_q <= flip_h_in;
            end
            draw_y_prev_q  <= DrawY;
            row_base_q     <= row_base_d;
            read_address_q <= read_address_d;
            hit1_q         <= hit;
            // The RAM registers data_Out while hit1 moves to hit2, so both arrive together.
            hit2_q         <= hit1_q;
            pix_idx_q      <= hit2_q ? data_Out[1:0] : 2'd0;
            pix_valid_q    <= hit2_q && (data_Out[1:0] != TRANSP_IDX);
        end
    end

    assign read_address = read_address_q;
    assign pix_idx      = pix_idx_q;
    assign pix_valid    = pix_valid_q;

endmodule

// File: tb/tb_sprite_reader_wall.sv
// Bench for sprite_reader_wall: a registered RAM model plus an arithmetic beam-to-address
// reference (address = (y-sy)*W + col) with directed edge cases and randomized raster frames.
module tb_sprite_reader_wall;
    localparam int W = 64;
    localparam int H = 33;

    logic        Clk         = 1'b0;
    logic        Reset_n     = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  pos_x_in    = '0;
    logic [9:0]  pos_y_in    = '0;
    logic        flip_h_in   = 1'b0;
    logic [9:0]  DrawX       = '0;
    logic [9:0]  DrawY       = '0;
    logic [18:0] read_address;
    logic [4:0]  data_Out    = '0;
    logic [1:0]  pix_idx;
    logic        pix_valid;

    sprite_reader_wall dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .pos_x_in     (pos_x_in),
        .pos_y_in     (pos_y_in),
        .flip_h_in    (flip_h_in),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .read_address (read_address),
        .data_Out     (data_Out),
        .pix_idx      (pix_idx),
        .pix_valid    (pix_valid)
    );

    always #5 Clk = ~Clk;

    // Registered-read frame RAM; upper data bits carry junk that the DUT must ignore.
    logic [1:0] mem [0:2111];
    always @(posedge Clk)
        data_Out <= {3'($urandom), (read_address < 19'd2112) ? mem[read_address[11:0]] : 2'b00};

    int tests = 0;
    int fails = 0;

    int         msx = 0;
    int         msy = 0;
    bit         mflip = 1'b0;
    int         prevY = 0;
    bit         orderly = 1'b0;
    int         qAddr [3];
    logic [1:0] qIdx  [3];
    logic       qVal  [3];
    bit         qOk   [3];

    task automatic clear_history(input bit ok);
        for (int i = 0; i < 3; i++) begin
            qAddr[i] = 0;
            qIdx[i]  = 2'b00;
            qVal[i]  = 1'b0;
            qOk[i]   = ok;
        end
    endtask

    // One beam sample: drive at negedge, predict, then return just after the next rising edge.
    // Entry 0 of the history matches read_address now, entry 2 matches pix_* now.
    task automatic beam(input int x, input int y, input bit fs);
        int a;
        int c;
        bit h;
        @(negedge Clk);
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        frame_start = fs;
        h = (x >= msx) && (x < msx + W) && (y >= msy) && (y < msy + H);
        c = mflip ? (W - 1 - (x - msx)) : (x - msx);
        a = h ? ((y - msy) * W + c) : 0;
        for (int i = 2; i > 0; i--) begin
            qAddr[i] = qAddr[i-1];
            qIdx[i]  = qIdx[i-1];
            qVal[i]  = qVal[i-1];
            qOk[i]   = qOk[i-1];
        end
        qAddr[0] = a;
        qIdx[0]  = h ? mem[a] : 2'b00;
        qVal[0]  = h && (mem[a] != 2'b00);
        qOk[0]   = !h || (orderly && (y == prevY));
        prevY    = y;
        if (fs) begin
            msx     = int'(pos_x_in);
            msy     = int'(pos_y_in);
            mflip   = flip_h_in;
            orderly = 1'b1;
        end
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic start_frame(input int x, input int y, input bit f);
        pos_x_in  = 10'(x);
        pos_y_in  = 10'(y);
        flip_h_in = f;
        beam(0, 520, 1'b1);
    endtask

    task automatic goto_row(input int from, input int to);
        for (int y = from; y <= to; y++) beam(0, y, 1'b0);
    endtask

    task automatic test_reset;
        DrawX = 10'd105;
        DrawY = 10'd52;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        tests++; if (read_address !== 19'd0) begin fails++; $display("[TB] FAIL reset_addr: got %0d expected 0", read_address); end
        tests++; if (pix_idx !== 2'd0) begin fails++; $display("[TB] FAIL reset_idx: got %0d expected 0", pix_idx); end
        tests++; if (pix_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b expected 0", pix_valid); end
        Reset_n = 1'b1;
        clear_history(1'b1);
    endtask

    task automatic test_basic_fetch;
        start_frame(100, 50, 1'b0);
        goto_row(0, 52);
        beam(105, 52, 1'b0);
        tests++; if (read_address !== 19'd133) begin fails++; $display("[TB] FAIL basic_addr: got %0d expected 133", read_address); end
        beam(105, 52, 1'b0);
        beam(105, 52, 1'b0);
        tests++; if (pix_idx !== mem[133]) begin fails++; $display("[TB] FAIL basic_idx: got %0d expected %0d", pix_idx, mem[133]); end
        tests++; if (pix_valid !== (mem[133] != 2'd0)) begin fails++; $display("[TB] FAIL basic_valid: got %0b expected %0b", pix_valid, mem[133] != 2'd0); end
    endtask

    task automatic test_transparency;
        mem[133] = 2'd0;
        repeat (3) beam(105, 52, 1'b0);
        tests++; if (pix_valid !== 1'b0 || pix_idx !== 2'd0) begin fails++; $display("[TB] FAIL transp_zero: got idx=%0d valid=%0b expected idx=0 valid=0", pix_idx, pix_valid); end
        mem[133] = 2'd2;
        repeat (3) beam(105, 52, 1'b0);
        tests++; if (pix_valid !== 1'b1 || pix_idx !== 2'd2) begin fails++; $display("[TB] FAIL transp_two: got idx=%0d valid=%0b expected idx=2 valid=1", pix_idx, pix_valid); end
    endtask

    task automatic test_h_edges;
        mem[191] = 2'd3;
        beam(163, 52, 1'b0);
        tests++; if (read_address !== 19'd191) begin fails++; $display("[TB] FAIL hedge_last_col: got %0d expected 191", read_address); end
        beam(164, 52, 1'b0);
        tests++; if (read_address !== 19'd0) begin fails++; $display("[TB] FAIL hedge_past_right: got %0d expected 0", read_address); end
        beam(99, 52, 1'b0);
        tests++; if (read_address !== 19'd0) begin fails++; $display("[TB] FAIL hedge_left_miss: got %0d expected 0", read_address); end
        tests++; if (pix_idx !== 2'd3 || pix_valid !== 1'b1) begin fails++; $display("[TB] FAIL hedge_last_pix: got idx=%0d valid=%0b expected idx=3 valid=1", pix_idx, pix_valid); end
        beam(99, 52, 1'b0);
        tests++; if (pix_idx !== 2'd0 || pix_valid !== 1'b0) begin fails++; $display("[TB] FAIL hedge_miss_pix: got idx=%0d valid=%0b expected idx=0 valid=0", pix_idx, pix_valid); end
        start_frame(100, 50, 1'b1);
        goto_row(0, 52);
        beam(100, 52, 1'b0);
        tests++; if (read_address !== 19'd191) begin fails++; $display("[TB] FAIL flip_left: got %0d expected 191", read_address); end
        beam(163, 52, 1'b0);
        tests++; if (read_address !== 19'd128) begin fails++; $display("[TB] FAIL flip_right: got %0d expected 128", read_address); end
    endtask

    task automatic test_position_latch;
        start_frame(100, 50, 1'b0);
        goto_row(0, 52);
        pos_x_in = 10'd300;
        beam(100, 52, 1'b0);
        tests++; if (read_address !== 19'd128) begin fails++; $display("[TB] FAIL latch_old_hit: got %0d expected 128", read_address); end
        beam(300, 52, 1'b0);
        tests++; if (read_address !== 19'd0) begin fails++; $display("[TB] FAIL latch_new_ignored: got %0d expected 0", read_address); end
        start_frame(300, 50, 1'b0);
        goto_row(0, 52);
        beam(100, 52, 1'b0);
        tests++; if (read_address !== 19'd0) begin fails++; $display("[TB] FAIL latch_old_gone: got %0d expected 0", read_address); end
        beam(300, 52, 1'b0);
        tests++; if (read_address !== 19'd128) begin fails++; $display("[TB] FAIL latch_new_left: got %0d expected 128", read_address); end
        beam(363, 52, 1'b0);
        tests++; if (read_address !== 19'd191) begin fails++; $display("[TB] FAIL latch_new_right: got %0d expected 191", read_address); end
        beam(364, 52, 1'b0);
        tests++; if (read_address !== 19'd0) begin fails++; $display("[TB] FAIL latch_new_past: got %0d expected 0", read_address); end
    endtask

    // The first sample of each line sees the previous row base, so each row is checked on its second sample.
    task automatic test_vertical_sweep;
        int exp;
        for (int f = 0; f < 2; f++) begin
            start_frame(100, 50, 1'b0);
            for (int y = 0; y <= 90; y++) begin
                beam(100, y, 1'b0);
                beam(101, y, 1'b0);
                exp = (y >= 50 && y <= 82) ? ((y - 50) * W + 1) : 0;
                tests++; if (read_address !== 19'(exp)) begin fails++; $display("[TB] FAIL vsweep frame %0d row %0d: got %0d expected %0d", f, y, read_address, exp); end
            end
        end
    endtask

    task automatic test_fs_priority;
        start_frame(100, 50, 1'b0);
        goto_row(0, 60);
        pos_y_in = 10'd55;
        beam(100, 61, 1'b1);
        orderly = 1'b0;
        beam(105, 61, 1'b0);
        tests++; if (read_address !== 19'd5) begin fails++; $display("[TB] FAIL fs_priority: got %0d expected 5", read_address); end
        beam(105, 62, 1'b0);
        beam(105, 62, 1'b0);
        tests++; if (read_address !== 19'd69) begin fails++; $display("[TB] FAIL fs_priority_next: got %0d expected 69", read_address); end
    endtask

    task automatic test_reset_midframe;
        start_frame(100, 50, 1'b0);
        goto_row(0, 52);
        repeat (3) beam(105, 52, 1'b0);
        tests++; if (read_address !== 19'd133) begin fails++; $display("[TB] FAIL midreset_pre: got %0d expected 133", read_address); end
        #2;
        Reset_n = 1'b0;
        #1;
        tests++; if (read_address !== 19'd0 || pix_idx !== 2'd0 || pix_valid !== 1'b0) begin fails++; $display("[TB] FAIL midreset_async: got addr=%0d idx=%0d valid=%0b expected 0 0 0", read_address, pix_idx, pix_valid); end
        @(negedge Clk);
        Reset_n = 1'b1;
        msx     = 0;
        msy     = 0;
        mflip   = 1'b0;
        orderly = 1'b0;
        clear_history(1'b1);
        beam(105, 52, 1'b0);
        tests++; if (read_address !== 19'd0) begin fails++; $display("[TB] FAIL midreset_invisible: got %0d expected 0", read_address); end
        beam(10, 0, 1'b0);
        beam(10, 0, 1'b0);
        tests++; if (read_address !== 19'd10) begin fails++; $display("[TB] FAIL midreset_origin: got %0d expected 10", read_address); end
    endtask

    task automatic test_random_frames;
        int sx;
        int sy;
        int n;
        int x;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 2112; i++) mem[i] = 2'($urandom);
            sx = (f == 0) ? 980 : int'($urandom_range(0, 1023));
            sy = int'($urandom_range(0, 470));
            start_frame(sx, sy, 1'($urandom_range(0, 1)));
            for (int y = (sy > 2 ? sy - 2 : 0); y <= sy + H + 1; y++) begin
                n = (y >= sy && y < sy + H) ? int'($urandom_range(3, 8)) : 1;
                for (int k = 0; k < n; k++) begin
                    if (k == 0 || $urandom_range(0, 5) == 0)
                        x = int'($urandom_range(0, 1023));
                    else
                        x = sx - 3 + int'($urandom_range(0, W + 5));
                    if (x < 0) x = 0;
                    if (x > 1023) x = 1023;
                    beam(x, y, 1'b0);
                    if (qOk[0]) begin
                        tests++;
                        if (read_address !== 19'(qAddr[0])) begin fails++; $display("[TB] FAIL rand_addr x=%0d y=%0d: got %0d expected %0d", x, y, read_address, qAddr[0]); end
                    end
                    if (qOk[2]) begin
                        tests++;
                        if (pix_idx !== qIdx[2] || pix_valid !== qVal[2]) begin fails++; $display("[TB] FAIL rand_pix y=%0d: got idx=%0d valid=%0b expected idx=%0d valid=%0b", y, pix_idx, pix_valid, qIdx[2], qVal[2]); end
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2112; i++) mem[i] = 2'($urandom);
        clear_history(1'b0);
        #1;
        Reset_n = 1'b0;
        test_reset;
        test_basic_fetch;
        test_transparency;
        test_h_edges;
        test_position_latch;
        test_vertical_sweep;
        test_fs_priority;
        test_reset_midframe;
        test_random_frames;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
